// File: rtl/i2c_read_scheduler.sv
// i2c_read_scheduler
//   Round-robin arbiter that shares one I2C read engine among four requesters.
//   Each granted transaction issues a start pulse and an address to the engine,
//   waits for completion under a watchdog, then returns a one-cycle response
//   to the requester that was granted.
//
// Parameters
//   TIMEOUT_CYC  engine watchdog limit in clk cycles (2..2^26-1)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req        per-requester read request (level)
//   req_addr   four 8-bit device addresses, requester i at [8i+7:8i]
//   gnt        one-hot grant, held from ISSUE through RESP
//   eng_start  one-cycle start pulse to the engine
//   eng_addr   device address to the engine, stable for the transaction
//   eng_abort  one-cycle pulse on watchdog expiry
//   eng_done   engine completion pulse
//   eng_nack   address NACK, qualified by eng_done
//   eng_data   read word, valid with eng_done
//   rsp_valid  one-hot response strobe to the granted requester
//   rsp_data   response word, held until the next response
//   rsp_err    NACK or timeout flag, valid with rsp_valid
//
// Build option
//   I2C_SCHED_RETRY_EN  when defined, a NACK on the first attempt re-issues
//                       the same read once; timeouts are never retried.

module i2c_read_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_addr,
    output logic [3:0]  gnt,
    output logic        eng_start,
    output logic [7:0]  eng_addr,
    output logic        eng_abort,
    input  logic        eng_done,
    input  logic        eng_nack,
    input  logic [15:0] eng_data,
    output logic [3:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  sel;
    logic [1:0]  last_grant;
    logic [1:0]  rr_pick;
    logic [1:0]  rr_idx;
    logic        rr_found;
    logic [25:0] watchdog;
    logic        timeout;
    logic        retry_now;

`ifdef I2C_SCHED_RETRY_EN
    logic        retried;
    assign retry_now = (state == WAIT) && eng_done && eng_nack && !retried;
`else
    assign retry_now = 1'b0;
`endif

    // Search starts one past the last granted index; k == 4 wraps back onto
    // last_grant itself so a lone requester is granted repeatedly.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            rr_idx = last_grant + k[1:0];
            if (!rr_found && req[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // eng_done in the expiry cycle takes precedence over the watchdog.
    assign timeout = (state == WAIT) && !eng_done &&
                     (watchdog == 26'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (eng_done) state_nxt = retry_now ? ISSUE : RESP;
                else if (timeout) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        eng_start = (state == ISSUE);
        eng_abort = timeout;
        if (state != IDLE) gnt = 4'b0001 << sel;
        if (state == RESP) rsp_valid = 4'b0001 << sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= 2'd3;
            eng_addr   <= '0;
            watchdog   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
`ifdef I2C_SCHED_RETRY_EN
            retried    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel      <= rr_pick;
                        eng_addr <= req_addr[8*rr_pick +: 8];
`ifdef I2C_SCHED_RETRY_EN
                        retried  <= 1'b0;
`endif
                    end
                end
                ISSUE: watchdog <= '0;
                WAIT: begin
                    watchdog <= watchdog + 26'd1;
                    if (eng_done) begin
                        if (!retry_now) begin
                            rsp_data <= eng_data;
                            rsp_err  <= eng_nack;
                        end
`ifdef I2C_SCHED_RETRY_EN
                        else retried <= 1'b1;
`endif
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: last_grant <= sel;
                default: ;
            endcase
        end
    end

endmodule
